match_controller: RTL and testbench
===================================

# match_controller

Round and match sequencer for the tic-tac-toe game. Drives the playing grid (clear, enable), tracks whose turn it is, owns the per-turn countdown that requests an automatic move on timeout, scores rounds, and declares a best-of-N match winner. Sits above the grid, player-toggle and timeout datapath, consuming the board's occupancy/victory signals and the move-commit strobe.

## Interface
- ROUNDS_TO_WIN, default 2: round wins needed to take the match (best-of-3); must be < 2^SCORE_W.
- TURN_LIMIT, default 15: ticks allowed per turn, range 1..31.
- END_HOLD, default 3: ticks the finished board is displayed before the next round, range 1..15.
- SCORE_W, default 3: width of score and draw counters.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a new match from IDLE or DONE.
- tick  in  1  one-cycle time-base enable (e.g. 1 Hz).
- move_commit  in  1  one-cycle strobe: a mark was written to the grid this cycle.
- winner  in  2  board victory code: 00 none, 01 P1, 10 P2, 11 treated as none.
- occupied  in  9  per-cell occupancy, bit0 = cell a ... bit8 = cell i.
- play_en  out  1  grid accepts moves.
- grid_clr  out  1  one-cycle pulse clearing the grid and the player toggle.
- turn_player  out  1  0 = P1, 1 = P2.
- first_player  out  1  player who opens the current round.
- time_left  out  5  remaining ticks in the current turn.
- turn_timeout  out  1  level; current turn expired, automatic move requested.
- p1_score, p2_score, draws  out  SCORE_W each  round tallies, saturating.
- match_winner  out  2  00 none, 01 P1, 10 P2.
- state  out  3  IDLE=0, CLEAR=1, PLAY=2, HOLD=3, DONE=4.

## Operation
- Reset: state IDLE; all outputs 0 (play_en 0, grid_clr 0, turn_player 0, first_player 0, time_left 0, scores 0, match_winner 00). Reset mid-operation aborts immediately to these values.
- IDLE: waits for start. On start: clear scores/draws/match_winner, first_player=0, go CLEAR.
- CLEAR, one cycle: grid_clr=1, turn_player<=first_player, time_left<=TURN_LIMIT, hold counter 0. Go PLAY.
- PLAY: play_en=1. Evaluate each cycle in strict priority:
  - 1. winner==01/10: increment that score (saturate at 2^SCORE_W-1), go HOLD.
  - 2. else occupied==9'h1FF: draws++ (saturating), go HOLD.
  - 3. else move_commit: toggle turn_player, reload time_left=TURN_LIMIT.
  - 4. else tick and time_left>0: time_left-1.
- turn_timeout = (state==PLAY) && (time_left==0). Stays high until move_commit reloads the turn; ticks at 0 are ignored.
- HOLD: play_en=0, time_left frozen. Each tick increments the hold counter. On the tick that reaches END_HOLD: if p1_score or p2_score == ROUNDS_TO_WIN, set match_winner (01/10) and go DONE; else toggle first_player and go CLEAR.
- DONE: play_en=0; scores and match_winner held. start → IDLE-style restart (clear tallies, first_player=0, CLEAR).
- start in CLEAR/PLAY/HOLD is ignored. move_commit outside PLAY is ignored.

## Timing
- All state/output changes are registered; outputs are pure functions of registers (no input-to-output combinational paths).
- start at edge N → state CLEAR and grid_clr high for cycle N+1 → PLAY at N+2.
- move_commit sampled at edge N → turn_player toggled and time_left=TURN_LIMIT from N+1. turn_timeout drops at N+1.
- Turn expiry: TURN_LIMIT ticks after reload, time_left reaches 0 and turn_timeout rises on the same edge.
- Winner/full board sampled at edge N → score updated and state HOLD at N+1 (play_en low from N+1).
- Round-to-round: END_HOLD ticks in HOLD, then one CLEAR cycle.
- Simultaneous win and full board: counts as a win, not a draw. Simultaneous move_commit and tick: reload wins, the tick is dropped.

## Test plan
- Reset mid-PLAY (time_left=7, p1_score=1) → on rst assertion, all outputs 0 and state=0 immediately, without waiting for a clock edge.
- start, then 3 move_commits → grid_clr one cycle at N+1, turn_player 0→1→0→1, time_left back to 15 after each commit.
- In PLAY with no moves, 15 ticks → time_left 0, turn_timeout=1. Extra ticks leave it at 0. A move_commit then gives turn_timeout=0 and time_left=15.
- winner=01 in PLAY → p1_score=1 and state=3. After 3 ticks, first_player=1, one grid_clr pulse, then PLAY with turn_player=1.
- occupied=9'h1FF with winner=00 → draws=1, scores unchanged. Same cycle with winner=10 → p2_score=1, draws=0.
- P2 wins two rounds → after the hold, match_winner=10 and state=4. start → scores 0, match_winner 00, first_player 0, then CLEAR.

Source files
------------

// File: rtl/match_controller.sv
// match_controller: round/match sequencer for tic-tac-toe.
// Clears and enables the grid, tracks turns and the per-turn countdown,
// tallies round results and declares the best-of-N match winner.
module match_controller #(
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned TURN_LIMIT    = 15,
    parameter int unsigned END_HOLD      = 3,
    parameter int unsigned SCORE_W       = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_tick,
    input  logic               i_move_commit,
    input  logic [1:0]         i_winner,
    input  logic [8:0]         i_occupied,
    output logic               o_play_en,
    output logic               o_grid_clr,
    output logic               o_turn_player,
    output logic               o_first_player,
    output logic [4:0]         o_time_left,
    output logic               o_turn_timeout,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [SCORE_W-1:0] o_draws,
    output logic [1:0]         o_match_winner,
    output logic [2:0]         o_state
);

    localparam int unsigned TIME_W  = 5;
    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] S_PLAY  = 3'd2;
    localparam logic [STATE_W-1:0] S_HOLD  = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

    localparam logic [TIME_W-1:0]  TURN_RELOAD = TIME_W'(TURN_LIMIT);
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(END_HOLD);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] WIN_SCORE   = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [8:0]         BOARD_FULL  = 9'h1FF;

    logic [STATE_W-1:0] r_state;
    logic               r_turn_player;
    logic               r_first_player;
    logic [TIME_W-1:0]  r_time_left;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic [SCORE_W-1:0] r_draws;
    logic [1:0]         r_match_winner;
    logic               r_play_en;
    logic               r_grid_clr;
    logic               r_turn_timeout;

    logic [STATE_W-1:0] w_state_nx;
    logic               w_turn_player_nx;
    logic               w_first_player_nx;
    logic [TIME_W-1:0]  w_time_left_nx;
    logic [HOLD_W-1:0]  w_hold_cnt_nx;
    logic [HOLD_W-1:0]  w_hold_inc;
    logic [SCORE_W-1:0] w_p1_score_nx;
    logic [SCORE_W-1:0] w_p2_score_nx;
    logic [SCORE_W-1:0] w_draws_nx;
    logic [1:0]         w_match_winner_nx;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

    assign w_hold_inc = r_hold_cnt + HOLD_W'(1);

    // Next-state and next-register values; flags are derived from the next state
    // so every output leaves a flop.
    always_comb begin
        w_state_nx        = r_state;
        w_turn_player_nx  = r_turn_player;
        w_first_player_nx = r_first_player;
        w_time_left_nx    = r_time_left;
        w_hold_cnt_nx     = r_hold_cnt;
        w_p1_score_nx     = r_p1_score;
        w_p2_score_nx     = r_p2_score;
        w_draws_nx        = r_draws;
        w_match_winner_nx = r_match_winner;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_p1_score_nx     = '0;
                    w_p2_score_nx     = '0;
                    w_draws_nx        = '0;
                    w_match_winner_nx = 2'b00;
                    w_first_player_nx = 1'b0;
                    w_state_nx        = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_turn_player_nx = r_first_player;
                w_time_left_nx   = TURN_RELOAD;
                w_hold_cnt_nx    = '0;
                w_state_nx       = S_PLAY;
            end
            S_PLAY: begin
                if (i_winner == 2'b01) begin
                    w_p1_score_nx = sat_inc(r_p1_score);
                    w_state_nx    = S_HOLD;
                end else if (i_winner == 2'b10) begin
                    w_p2_score_nx = sat_inc(r_p2_score);
                    w_state_nx    = S_HOLD;
                end else if (i_occupied == BOARD_FULL) begin
                    w_draws_nx = sat_inc(r_draws);
                    w_state_nx = S_HOLD;
                end else if (i_move_commit) begin
                    w_turn_player_nx = ~r_turn_player;
                    w_time_left_nx   = TURN_RELOAD;
                end else if (i_tick && (r_time_left != '0)) begin
                    w_time_left_nx = r_time_left - TIME_W'(1);
                end
            end
            S_HOLD: begin
                if (i_tick) begin
                    w_hold_cnt_nx = w_hold_inc;
                    if (w_hold_inc == HOLD_LAST) begin
                        if (r_p1_score == WIN_SCORE) begin
                            w_match_winner_nx = 2'b01;
                            w_state_nx        = S_DONE;
                        end else if (r_p2_score == WIN_SCORE) begin
                            w_match_winner_nx = 2'b10;
                            w_state_nx        = S_DONE;
                        end else begin
                            w_first_player_nx = ~r_first_player;
                            w_state_nx        = S_CLEAR;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts everything immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_turn_player  <= 1'b0;
            r_first_player <= 1'b0;
            r_time_left    <= '0;
            r_hold_cnt     <= '0;
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_draws        <= '0;
            r_match_winner <= 2'b00;
            r_play_en      <= 1'b0;
            r_grid_clr     <= 1'b0;
            r_turn_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_turn_player  <= w_turn_player_nx;
            r_first_player <= w_first_player_nx;
            r_time_left    <= w_time_left_nx;
            r_hold_cnt     <= w_hold_cnt_nx;
            r_p1_score     <= w_p1_score_nx;
            r_p2_score     <= w_p2_score_nx;
            r_draws        <= w_draws_nx;
            r_match_winner <= w_match_winner_nx;
            r_play_en      <= (w_state_nx == S_PLAY);
            r_grid_clr     <= (w_state_nx == S_CLEAR);
            r_turn_timeout <= (w_state_nx == S_PLAY) && (w_time_left_nx == '0);
        end
    end

    assign o_play_en      = r_play_en;
    assign o_grid_clr     = r_grid_clr;
    assign o_turn_player  = r_turn_player;
    assign o_first_player = r_first_player;
    assign o_time_left    = r_time_left;
    assign o_turn_timeout = r_turn_timeout;
    assign o_p1_score     = r_p1_score;
    assign o_p2_score     = r_p2_score;
    assign o_draws        = r_draws;
    assign o_match_winner = r_match_winner;
    assign o_state        = r_state;

endmodule

// File: tb/tb_match_controller.sv
// Testbench for match_controller: directed scenarios plus a randomized run
// checked against a rule-level reference model.
module tb_match_controller;

    localparam int TL   = 15;
    localparam int EH   = 3;
    localparam int RW   = 2;
    localparam int SMAX = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       commit = 1'b0;
    logic [1:0] winner = 2'b00;
    logic [8:0] occ = 9'h000;

    logic       o_play_en, o_grid_clr, o_turn_player, o_first_player, o_turn_timeout;
    logic [4:0] o_time_left;
    logic [2:0] o_p1_score, o_p2_score, o_draws, o_state;
    logic [1:0] o_match_winner;

    int total = 0;
    int bad   = 0;

    // Reference model: game quantities kept as plain integers
    int m_state, m_tp, m_fp, m_tl, m_hc, m_p1, m_p2, m_dr, m_mw;

    match_controller dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_tick        (tick),
        .i_move_commit (commit),
        .i_winner      (winner),
        .i_occupied    (occ),
        .o_play_en     (o_play_en),
        .o_grid_clr    (o_grid_clr),
        .o_turn_player (o_turn_player),
        .o_first_player(o_first_player),
        .o_time_left   (o_time_left),
        .o_turn_timeout(o_turn_timeout),
        .o_p1_score    (o_p1_score),
        .o_p2_score    (o_p2_score),
        .o_draws       (o_draws),
        .o_match_winner(o_match_winner),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_state = 0; m_tp = 0; m_fp = 0; m_tl = 0; m_hc = 0;
        m_p1 = 0; m_p2 = 0; m_dr = 0; m_mw = 0;
    endfunction

    function automatic void m_new_match();
        m_p1 = 0; m_p2 = 0; m_dr = 0; m_mw = 0; m_fp = 0; m_state = 1;
    endfunction

    function automatic int sat(input int v);
        return (v + 1 > SMAX) ? SMAX : v + 1;
    endfunction

    // One clock edge of the game rules
    function automatic void m_update(input logic st, input logic tk, input logic mc,
                                     input logic [1:0] wn, input logic [8:0] oc);
        case (m_state)
            0, 4: if (st) m_new_match();
            1: begin m_tp = m_fp; m_tl = TL; m_hc = 0; m_state = 2; end
            2: begin
                if (wn == 2'b01)       begin m_p1 = sat(m_p1); m_state = 3; end
                else if (wn == 2'b10)  begin m_p2 = sat(m_p2); m_state = 3; end
                else if (oc == 9'h1FF) begin m_dr = sat(m_dr); m_state = 3; end
                else if (mc)           begin m_tp = 1 - m_tp; m_tl = TL; end
                else if (tk && m_tl > 0) m_tl = m_tl - 1;
            end
            3: if (tk) begin
                m_hc = m_hc + 1;
                if (m_hc == EH) begin
                    if (m_p1 == RW)      begin m_mw = 1; m_state = 4; end
                    else if (m_p2 == RW) begin m_mw = 2; m_state = 4; end
                    else                 begin m_fp = 1 - m_fp; m_state = 1; end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [23:0] m_vec();
        return {(m_state == 2), (m_state == 1), 1'(m_tp), 1'(m_fp), 5'(m_tl),
                (m_state == 2 && m_tl == 0), 3'(m_p1), 3'(m_p2), 3'(m_dr),
                2'(m_mw), 3'(m_state)};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {o_play_en, o_grid_clr, o_turn_player, o_first_player, o_time_left,
                o_turn_timeout, o_p1_score, o_p2_score, o_draws, o_match_winner, o_state};
    endfunction

    // Apply inputs across one rising edge, then sample 1 time unit later
    task automatic step(input logic st, input logic tk, input logic mc,
                        input logic [1:0] wn, input logic [8:0] oc);
        start = st; tick = tk; commit = mc; winner = wn; occ = oc;
        @(posedge clk);
        m_update(st, tk, mc, wn, oc);
        #1;
        start = 1'b0; tick = 1'b0; commit = 1'b0; winner = 2'b00; occ = 9'h000;
    endtask

    task automatic hold_ticks();
        for (int i = 0; i < EH; i++) step(0, 1, 0, 2'b00, 9'h000);
    endtask

    task automatic test_reset();
        m_reset();
        #12;
        total++;
        if (dut_vec() !== 24'h0) begin
            bad++; $display("FAIL reset_values: got %h expected %h", dut_vec(), 24'h0);
        end
        @(negedge clk); rst = 1'b0;
        step(0, 1, 1, 2'b01, 9'h1FF);
        total++;
        if (o_state !== 3'd0) begin
            bad++; $display("FAIL idle_ignores_inputs: state %0d expected 0", o_state);
        end
    endtask

    task automatic test_start_moves();
        step(1, 0, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr, o_play_en} !== {3'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL start_clear: state/clr/en %b expected 00110",
                            {o_state, o_grid_clr, o_play_en});
        end
        step(0, 0, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr, o_play_en, o_turn_player, o_time_left} !==
            {3'd2, 1'b0, 1'b1, 1'b0, 5'd15}) begin
            bad++; $display("FAIL enter_play: state %0d clr %b en %b tp %b tl %0d",
                            o_state, o_grid_clr, o_play_en, o_turn_player, o_time_left);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 2'b00, 9'h003);
            step(0, 0, 1, 2'b00, 9'h007);
            total++;
            if ({o_turn_player, o_time_left} !== {1'((i + 1) % 2), 5'd15}) begin
                bad++; $display("FAIL commit_%0d: tp %b tl %0d expected tp %0d tl 15",
                                i, o_turn_player, o_time_left, (i + 1) % 2);
            end
        end
        step(1, 0, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr} !== {3'd2, 1'b0}) begin
            bad++; $display("FAIL start_in_play: state %0d clr %b expected 2 0",
                            o_state, o_grid_clr);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TL - 1; i++) step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_time_left, o_turn_timeout} !== {5'd1, 1'b0}) begin
            bad++; $display("FAIL timeout_early: tl %0d to %b expected 1 0",
                            o_time_left, o_turn_timeout);
        end
        step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_time_left, o_turn_timeout} !== {5'd0, 1'b1}) begin
            bad++; $display("FAIL timeout_expire: tl %0d to %b expected 0 1",
                            o_time_left, o_turn_timeout);
        end
        step(0, 1, 0, 2'b00, 9'h000);
        step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_time_left, o_turn_timeout} !== {5'd0, 1'b1}) begin
            bad++; $display("FAIL timeout_extra_ticks: tl %0d to %b expected 0 1",
                            o_time_left, o_turn_timeout);
        end
        step(0, 1, 1, 2'b00, 9'h000);
        total++;
        if ({o_time_left, o_turn_timeout, o_turn_player} !== {5'd15, 1'b0, 1'b0}) begin
            bad++; $display("FAIL timeout_reload: tl %0d to %b tp %b expected 15 0 0",
                            o_time_left, o_turn_timeout, o_turn_player);
        end
    endtask

    task automatic test_win_p1();
        step(0, 0, 0, 2'b01, 9'h000);
        total++;
        if ({o_p1_score, o_state, o_play_en} !== {3'd1, 3'd3, 1'b0}) begin
            bad++; $display("FAIL p1_win: p1 %0d state %0d en %b expected 1 3 0",
                            o_p1_score, o_state, o_play_en);
        end
        step(0, 0, 1, 2'b00, 9'h000);
        step(0, 1, 0, 2'b00, 9'h000);
        step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_time_left} !== {3'd3, 5'd15}) begin
            bad++; $display("FAIL hold_wait: state %0d tl %0d expected 3 15",
                            o_state, o_time_left);
        end
        step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr, o_first_player} !== {3'd1, 1'b1, 1'b1}) begin
            bad++; $display("FAIL hold_to_clear: state %0d clr %b fp %b expected 1 1 1",
                            o_state, o_grid_clr, o_first_player);
        end
        step(0, 0, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr, o_turn_player} !== {3'd2, 1'b0, 1'b1}) begin
            bad++; $display("FAIL round2_play: state %0d clr %b tp %b expected 2 0 1",
                            o_state, o_grid_clr, o_turn_player);
        end
    endtask

    task automatic test_draw();
        step(0, 0, 0, 2'b00, 9'h1FF);
        total++;
        if ({o_draws, o_p1_score, o_p2_score, o_state} !== {3'd1, 3'd1, 3'd0, 3'd3}) begin
            bad++; $display("FAIL draw: dr %0d p1 %0d p2 %0d state %0d expected 1 1 0 3",
                            o_draws, o_p1_score, o_p2_score, o_state);
        end
        hold_ticks();
        step(0, 0, 0, 2'b00, 9'h000);
        step(0, 0, 0, 2'b10, 9'h1FF);
        total++;
        if ({o_p2_score, o_draws, o_state} !== {3'd1, 3'd1, 3'd3}) begin
            bad++; $display("FAIL win_beats_full: p2 %0d dr %0d state %0d expected 1 1 3",
                            o_p2_score, o_draws, o_state);
        end
        hold_ticks();
        step(0, 0, 0, 2'b00, 9'h000);
    endtask

    task automatic test_match_p2();
        step(0, 0, 0, 2'b10, 9'h000);
        total++;
        if ({o_p2_score, o_match_winner} !== {3'd2, 2'b00}) begin
            bad++; $display("FAIL p2_second_win: p2 %0d mw %b expected 2 00",
                            o_p2_score, o_match_winner);
        end
        hold_ticks();
        total++;
        if ({o_match_winner, o_state, o_play_en} !== {2'b10, 3'd4, 1'b0}) begin
            bad++; $display("FAIL match_done: mw %b state %0d en %b expected 10 4 0",
                            o_match_winner, o_state, o_play_en);
        end
        step(0, 1, 1, 2'b01, 9'h000);
        total++;
        if ({o_state, o_p1_score, o_p2_score} !== {3'd4, 3'd1, 3'd2}) begin
            bad++; $display("FAIL done_holds: state %0d p1 %0d p2 %0d expected 4 1 2",
                            o_state, o_p1_score, o_p2_score);
        end
        step(1, 0, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_grid_clr, o_p1_score, o_p2_score, o_draws, o_match_winner, o_first_player}
            !== {3'd1, 1'b1, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0}) begin
            bad++; $display("FAIL restart: state %0d clr %b p1 %0d p2 %0d dr %0d mw %b fp %b",
                            o_state, o_grid_clr, o_p1_score, o_p2_score, o_draws,
                            o_match_winner, o_first_player);
        end
        step(0, 0, 0, 2'b00, 9'h000);
    endtask

    task automatic test_reset_mid_play();
        step(0, 0, 0, 2'b01, 9'h000);
        hold_ticks();
        step(0, 0, 0, 2'b00, 9'h000);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 2'b00, 9'h000);
        total++;
        if ({o_state, o_time_left, o_p1_score} !== {3'd2, 5'd7, 3'd1}) begin
            bad++; $display("FAIL pre_reset: state %0d tl %0d p1 %0d expected 2 7 1",
                            o_state, o_time_left, o_p1_score);
        end
        #2 rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (dut_vec() !== 24'h0) begin
            bad++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 24'h0);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        logic st, tk, mc;
        logic [1:0] wn;
        logic [8:0] oc;
        for (int c = 0; c < 2000; c++) begin
            st = ($urandom_range(0, 99) < 3);
            tk = ($urandom_range(0, 99) < 35);
            mc = ($urandom_range(0, 99) < 12);
            wn = ($urandom_range(0, 99) < 5) ? 2'($urandom_range(1, 3)) : 2'b00;
            oc = ($urandom_range(0, 99) < 3) ? 9'h1FF : 9'($urandom_range(0, 255));
            step(st, tk, mc, wn, oc);
            total++;
            if (dut_vec() !== m_vec()) begin
                bad++; $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec(), m_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_moves();
        test_timeout();
        test_win_p1();
        test_draw();
        test_match_p2();
        test_reset_mid_play();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
